// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a registered grant index and a matching one-hot grant.
// Define ARB_TIMEOUT_EN to revoke a grant held for TIMEOUT_CYCLES cycles without release.
module rr_arbiter8 #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic       grantValid,
    output logic [2:0] grantIdx,
    output logic [7:0] grantOneHot,
    output logic       timeoutEvt
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_reg, state_next;
    logic [2:0] ptr_reg, ptr_next;
    logic       valid_reg, valid_next;
    logic [2:0] idx_reg, idx_next;
    logic [7:0] onehot_reg, onehot_next;
    logic       tevt_reg, tevt_next;

    logic [7:0] rot_req;
    logic [2:0] win_off;
    logic [2:0] winner;
    logic [7:0] win_onehot;
    logic       release_c;
    logic       timeout_hit;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("rr_arbiter8: TIMEOUT_CYCLES must be in 2..65535");
    end

    // rot_req[k] is the request sitting k places after the priority pointer.
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
        assign rot_req[gi] = req[3'(ptr_reg + 3'(gi))];
    end

    always_comb begin
        win_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot_req[i]) begin
                win_off = 3'(i);
            end
        end
    end

    assign winner = ptr_reg + win_off;

    for (genvar gi = 0; gi < 8; gi++) begin : g_onehot
        assign win_onehot[gi] = (winner == 3'(gi));
    end

    assign release_c = done | ~req[idx_reg];

`ifdef ARB_TIMEOUT_EN
    logic [15:0] hold_cnt_reg;

    // Sits at zero in IDLE, so the first GRANT cycle always starts from zero.
    always_ff @(posedge clk) begin
        if (rst || state_reg == IDLE) begin
            hold_cnt_reg <= 16'd0;
        end else begin
            hold_cnt_reg <= hold_cnt_reg + 16'd1;
        end
    end

    assign timeout_hit = (state_reg == GRANT) && (hold_cnt_reg == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        valid_next  = valid_reg;
        idx_next    = idx_reg;
        onehot_next = onehot_reg;
        tevt_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next  = GRANT;
                    valid_next  = 1'b1;
                    idx_next    = winner;
                    onehot_next = win_onehot;
                end
            end
            GRANT: begin
                if (release_c || timeout_hit) begin
                    state_next  = IDLE;
                    valid_next  = 1'b0;
                    idx_next    = 3'd0;
                    onehot_next = 8'h00;
                    ptr_next    = idx_reg + 3'd1;
                    // A normal release on the terminal count is not reported as a timeout.
                    tevt_next   = timeout_hit & ~release_c;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            ptr_reg    <= 3'd0;
            valid_reg  <= 1'b0;
            idx_reg    <= 3'd0;
            onehot_reg <= 8'h00;
            tevt_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            valid_reg  <= valid_next;
            idx_reg    <= idx_next;
            onehot_reg <= onehot_next;
            tevt_reg   <= tevt_next;
        end
    end

    assign grantValid  = valid_reg;
    assign grantIdx    = idx_reg;
    assign grantOneHot = onehot_reg;
    assign timeoutEvt  = tevt_reg;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: a behavioural model predicts every cycle's outputs,
// a monitor compares them, and grant-order logs are checked against fixed sequences.
module tb_rr_arbiter8;

    localparam int TO = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic       grantValid;
    logic [2:0] grantIdx;
    logic [7:0] grantOneHot;
    logic       timeoutEvt;

    rr_arbiter8 #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .done       (done),
        .grantValid (grantValid),
        .grantIdx   (grantIdx),
        .grantOneHot(grantOneHot),
        .timeoutEvt (timeoutEvt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       v;
        logic [2:0] idx;
        logic [7:0] oh;
        logic       te;
    } exp_t;

    exp_t exp_q[$];
    int   glog[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Behavioural model: current owner (or none), priority pointer, cycles held.
    bit m_valid = 0;
    int m_idx = 0;
    int m_ptr = 0;
    int m_cnt = 0;
    bit m_tevt = 0;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, expv);
        end
    endtask

    task automatic model(input logic [7:0] r, input bit d, input bit s);
        exp_t e;
        bit   rel, tout, found;
        if (s) begin
            m_valid = 0; m_idx = 0; m_ptr = 0; m_cnt = 0; m_tevt = 0;
        end else begin
            m_tevt = 0;
            if (!m_valid) begin
                found = 0;
                for (int k = 0; k < 8; k++) begin
                    if (!found && r[(m_ptr + k) % 8]) begin
                        found = 1;
                        m_idx = (m_ptr + k) % 8;
                    end
                end
                if (found) begin
                    m_valid = 1;
                    m_cnt = 0;
                end
            end else begin
                rel = d || !r[m_idx];
                tout = 0;
`ifdef ARB_TIMEOUT_EN
                tout = !rel && (m_cnt == TO - 1);
`endif
                if (rel || tout) begin
                    m_ptr = (m_idx + 1) % 8;
                    m_valid = 0;
                    m_idx = 0;
                    m_tevt = tout;
                end else begin
                    m_cnt++;
                end
            end
        end
        e.v   = m_valid;
        e.idx = 3'(m_idx);
        e.oh  = m_valid ? 8'(1 << m_idx) : 8'h00;
        e.te  = m_tevt;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs, predict the result of the coming edge, move to next negedge.
    task automatic step(input logic [7:0] r, input bit d, input bit s);
        req  = r;
        done = d;
        rst  = s;
        model(r, d, s);
        @(negedge clk);
    endtask

    // Idle -> grant, first grant cycle, done on the second grant cycle.
    task automatic serve(input logic [7:0] r);
        step(r, 0, 0);
        step(r, 0, 0);
        step(r, 1, 0);
    endtask

    task automatic check_log(input string name, input int expv[$]);
        chk({name, "_len"}, 8'(glog.size()), 8'(expv.size()));
        for (int i = 0; i < expv.size() && i < glog.size(); i++) begin
            chk(name, 8'(glog[i]), 8'(expv[i]));
        end
    endtask

    // Monitor: one comparison set per clock edge that has a prediction queued.
    initial begin
        exp_t e;
        bit   prev_v = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("grantValid", 8'(grantValid), 8'(e.v));
                chk("grantIdx", 8'(grantIdx), 8'(e.idx));
                chk("grantOneHot", grantOneHot, e.oh);
                chk("timeoutEvt", 8'(timeoutEvt), 8'(e.te));
                if (grantValid === 1'b1 && !prev_v) glog.push_back(int'(grantIdx));
                prev_v = (grantValid === 1'b1);
            end
        end
    end

    initial begin
        int exp_list[$];
        logic [7:0] rr;
        req = 8'h00; done = 0; rst = 1;

        // Reset held with all requesting, then first grant goes to 0.
        repeat (3) step(8'hFF, 0, 1);
        step(8'hFF, 0, 0);
        step(8'hFF, 1, 0);
        step(8'h00, 0, 0);

        // Rotation 0..7,0 with done on the second grant cycle.
        step(8'h00, 0, 1);
        glog.delete();
        repeat (9) serve(8'hFF);
        exp_list.delete();
        for (int i = 0; i < 9; i++) exp_list.push_back(i % 8);
        check_log("rotation", exp_list);

        // Sparse requests wrapping past 7 from ptr=6.
        step(8'h00, 0, 1);
        repeat (6) serve(8'hFF);
        glog.delete();
        repeat (3) serve(8'h05);
        exp_list = '{0, 2, 0};
        check_log("sparse_wrap", exp_list);

        // Owner 3 is not preempted; dropping req[3] hands over to 4.
        step(8'h00, 0, 1);
        glog.delete();
        step(8'h08, 0, 0);
        repeat (20) step(8'hFF, 0, 0);
        step(8'hF7, 0, 0);
        step(8'hF7, 0, 0);
        step(8'hF7, 1, 0);
        step(8'h00, 0, 0);
        exp_list = '{3, 4};
        check_log("hold", exp_list);

        // Reset in the middle of a grant.
        step(8'h00, 0, 1);
        glog.delete();
        step(8'h20, 0, 0);
        step(8'h20, 0, 0);
        step(8'h20, 0, 1);
        step(8'h20, 0, 0);
        step(8'h20, 1, 0);
        exp_list = '{5, 5};
        check_log("mid_reset", exp_list);

        // Hold without done: timeout build hands over after TO cycles, default holds.
        step(8'h00, 0, 1);
        glog.delete();
        repeat (14) step(8'h03, 0, 0);
`ifdef ARB_TIMEOUT_EN
        exp_list = '{0, 1, 0};
`else
        exp_list = '{0};
`endif
        check_log("timeout", exp_list);

        // Randomized traffic.
        step(8'h00, 0, 1);
        rr = 8'h00;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) rr = 8'($urandom & $urandom);
            step(rr, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
        end
        step(8'h00, 0, 0);

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain cyc=%0d got=%0d exp=0", cyc, exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one 8-way resource between 8 requesters.
- Produces a registered 3-bit grant index plus the matching one-hot grant vector, i.e. the index-to-one-hot select that drives downstream 8-way muxes and enables.
- Grant is held until the owner signals completion or drops its request. Priority then rotates so every active requester is served within 8 grants.

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles one owner may hold the grant; used only when ARB_TIMEOUT_EN is defined; legal range 2..65535.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  8  request per requester; bit i = requester i
- done  input  1  owner finished; single-cycle pulse, ignored when grantValid=0
- grantValid  output  1  a grant is active
- grantIdx  output  3  index of current owner; 0 when grantValid=0
- grantOneHot  output  8  (1 << grantIdx) when grantValid=1, else 8'h00
- timeoutEvt  output  1  one-cycle pulse when a grant is revoked by timeout (ARB_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, ptr=0, grantValid=0, grantIdx=0, grantOneHot=8'h00, timeoutEvt=0, hold counter=0.
- rst asserted mid-grant: grant is dropped on that same edge and ptr returns to 0. No done is required.
- States: IDLE, GRANT. All outputs are registered.
- IDLE:
  - If req==0, stay in IDLE.
  - Else winner = first set bit of req scanning ptr, ptr+1, ... ptr+7 (mod 8).
  - Next edge: state=GRANT, grantIdx=winner, grantValid=1, grantOneHot=1<<winner.
  - Latency is 1 cycle from a sampled request to a visible grant.
- GRANT, release condition = done==1 OR req[grantIdx]==0:
  - On release, next edge: state=IDLE, grantValid=0, grantOneHot=0, grantIdx=0, ptr=(ownerIdx+1) mod 8. The 3-bit add wraps, so 7 -> 0.
  - There is always exactly one idle cycle between consecutive grants. No back-to-back handoff.
  - Without release, hold all outputs unchanged. Requests from other requesters do not preempt the owner.
- Simultaneous events:
  - done and a deassertion of req[owner] in the same cycle count as a single release.
  - done while in IDLE is ignored.
  - A requester still requesting after its release is re-considered in IDLE with lowest priority, because ptr has moved past it.
- Invariants: grantOneHot always equals decode(grantIdx) gated by grantValid. At most one bit is set. grantOneHot is never nonzero while grantValid=0.
- Fairness: with all 8 requesting continuously and done pulsed each grant, the grant order is 0,1,2,...,7,0,...

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on every grant and increments every GRANT cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 without a release, the next edge forces release: same as a done release, with ptr advancing.
  - timeoutEvt pulses high for exactly that one cycle, aligned with grantValid falling.
  - A normal release on the same cycle as the terminal count takes precedence, and timeoutEvt stays 0.
- Not defined:
  - No counter logic is present and grants are held indefinitely.
  - timeoutEvt is constant 0 and TIMEOUT_CYCLES has no effect.

Test Plan:
- Reset: hold rst 3 cycles with req=8'hFF -> grantValid=0, grantOneHot=8'h00, grantIdx=0 throughout. First grant after rst falls goes to idx 0 (grantOneHot=8'h01) one cycle later.
- Rotation: req=8'hFF constant, pulse done on the 2nd cycle of each grant -> grantIdx sequence 0,1,...,7,0. grantOneHot sequence 01,02,04,...,80,01. One idle cycle between each grant.
- Sparse and wrap: set ptr to 6 via grants 0..5, then req=8'b0000_0101 -> grant idx 0 (8'h01), then idx 2 (8'h04), then 0 again.
- Hold and no preemption: grant idx 3 with req=8'h08. Raise req=8'hFF for 20 cycles without done -> grantIdx stays 3. Drop req[3] -> grant released next edge, then idx 4 is granted.
- Mid-grant reset: grant idx 5, assert rst for 1 cycle -> grantValid=0 on that edge. After rst, req=8'h20 gives idx 5 again (ptr=0, first set bit is 5).
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): req=8'h03 held, no done -> idx 0 held exactly 4 cycles, timeoutEvt=1 for 1 cycle, then idx 1 granted. Without the macro, idx 0 is held indefinitely and timeoutEvt stays 0.
